// File: rtl/adder_rr_scheduler.sv
// Round-robin burst scheduler that time-shares one N-bit wrapping adder among NREQ flit sources.
// Optional macro ADDER_ACTIVITY_COUNT_EN adds act_flits/act_toggles activity counters.
module adder_rr_scheduler #(
    parameter int N         = 27,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 20,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_sum,
    output logic [IDW-1:0]    out_id,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
`ifdef ADDER_ACTIVITY_COUNT_EN
    ,
    output logic [31:0]       act_flits,
    output logic [31:0]       act_toggles
`endif
);

    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [CNTW-1:0] flit_cnt;

    logic            grant_ready;
    logic            accept;
    logic            burst_end;
    logic [IDW-1:0]  grant_inc;
    logic [N-1:0]    a_sel;
    logic [N-1:0]    b_sel;
    logic [N-1:0]    sum_next;

    // Carry out of the top bit is intentionally discarded.
    function automatic logic [N-1:0] add_wrap(input logic [N-1:0] a, input logic [N-1:0] b);
        return a + b;
    endfunction

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        logic [IDW:0]   idx;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (!found && v[idx[IDW-1:0]]) begin
                pick  = idx[IDW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_ready = (state == BURST) && (!out_valid || out_ready);
    assign accept      = grant_ready && req_valid[grant_id];
    assign burst_end   = accept && (req_last[grant_id] || (flit_cnt == CNTW'(MAX_BURST - 1)));
    assign grant_inc   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign a_sel       = req_a[int'(grant_id)*N +: N];
    assign b_sel       = req_b[int'(grant_id)*N +: N];
    assign sum_next    = add_wrap(a_sel, b_sel);

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = grant_ready;
    end

    // Arbitration costs one IDLE cycle between bursts; no flit is taken in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            grant_id <= '0;
            flit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= rr_pick(req_valid, rr_ptr);
                        flit_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (accept) begin
                        flit_cnt <= flit_cnt + 1'b1;
                        if (burst_end) begin
                            rr_ptr <= grant_inc;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: result register; loading and draining in the same cycle sustains one flit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_id    <= grant_id;
            out_last  <= burst_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADDER_ACTIVITY_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_flits   <= '0;
            act_toggles <= '0;
        end else if (accept) begin
            act_flits   <= act_flits + 32'd1;
            act_toggles <= act_toggles + 32'($countones(sum_next ^ out_sum));
        end
    end
`endif

endmodule
